// File: rtl/btb_maint_ctrl_pkg.sv
// Shared BTB maintenance types: entry layout, write-port bundle and FSM states.
package bp_pkg;

  localparam int BTB_ENTRIES = 32;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W   = 20;
  localparam int BTB_XLEN    = 32;
  localparam int BTB_CNT_W   = 16;

  localparam logic [BTB_IDX_W-1:0] BTB_LAST_IDX = BTB_IDX_W'(BTB_ENTRIES - 1);

  typedef struct packed {
    logic [BTB_TAG_W-1:0] tag;
    logic                 valid;
    logic [BTB_XLEN-1:0]  target;
  } btb_entry_t;

  typedef struct packed {
    logic                 we;
    logic [BTB_IDX_W-1:0] idx;
    btb_entry_t           entry;
  } btb_wr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    REPLAY = 2'd2
  } maint_state_e;

  function automatic btb_entry_t mk_entry(input logic [BTB_TAG_W-1:0] tag,
                                          input logic [BTB_XLEN-1:0]  target);
    btb_entry_t e;
    e.tag    = tag;
    e.valid  = 1'b1;
    e.target = target;
    return e;
  endfunction

endpackage

// File: rtl/btb_maint_ctrl_if.sv
// Update/invalidate request bus and BTB write-port bus of the maintenance controller.
interface btb_maint_if;
  import bp_pkg::*;

  logic                 upd_valid_i;
  logic [BTB_IDX_W-1:0] upd_idx_i;
  logic [BTB_TAG_W-1:0] upd_tag_i;
  logic [BTB_XLEN-1:0]  upd_target_i;
  logic                 inv_req_i;

  logic                 btb_we_o;
  logic [BTB_IDX_W-1:0] btb_widx_o;
  logic [BTB_TAG_W-1:0] btb_wtag_o;
  logic                 btb_wvalid_o;
  logic [BTB_XLEN-1:0]  btb_wtarget_o;
  logic                 inv_busy_o;
  logic                 inv_done_o;
  logic                 lookup_block_o;
  logic [BTB_CNT_W-1:0] drop_cnt_o;

  modport master (
    output upd_valid_i, upd_idx_i, upd_tag_i, upd_target_i, inv_req_i,
    input  btb_we_o, btb_widx_o, btb_wtag_o, btb_wvalid_o, btb_wtarget_o,
    input  inv_busy_o, inv_done_o, lookup_block_o, drop_cnt_o
  );

  modport slave (
    input  upd_valid_i, upd_idx_i, upd_tag_i, upd_target_i, inv_req_i,
    output btb_we_o, btb_widx_o, btb_wtag_o, btb_wvalid_o, btb_wtarget_o,
    output inv_busy_o, inv_done_o, lookup_block_o, drop_cnt_o
  );

endinterface

// File: rtl/btb_maint_ctrl_upd_buf.sv
// One-entry pending-update register with overwrite detection and a
// saturating count of updates lost to overwrite.
module btb_upd_buf
  import bp_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_load,
  input  logic                 i_consume,
  input  logic [BTB_IDX_W-1:0] i_idx,
  input  btb_entry_t           i_entry,
  output logic                 o_full,
  output logic [BTB_IDX_W-1:0] o_idx,
  output btb_entry_t           o_entry,
  output logic [BTB_CNT_W-1:0] o_drop_cnt
);

  logic                 r_full;
  logic [BTB_IDX_W-1:0] r_idx;
  btb_entry_t           r_entry;
  logic [BTB_CNT_W-1:0] r_drop;
  logic                 w_overwrite;

  // Loading while the held entry is simultaneously consumed is a hand-off, not a loss.
  assign w_overwrite = i_load & r_full & ~i_consume;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full  <= 1'b0;
      r_idx   <= '0;
      r_entry <= '0;
      r_drop  <= '0;
    end else begin
      if (i_load) begin
        r_full  <= 1'b1;
        r_idx   <= i_idx;
        r_entry <= i_entry;
      end else if (i_consume) begin
        r_full  <= 1'b0;
        r_idx   <= '0;
        r_entry <= '0;
      end
      if (w_overwrite && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign o_full     = r_full;
  assign o_idx      = r_idx;
  assign o_entry    = r_entry;
  assign o_drop_cnt = r_drop;

endmodule

// File: rtl/btb_maint_ctrl.sv
// Owner of the BTB write port: EX updates, whole-table invalidation sweeps and
// replay of an update that arrived while a sweep was running.
//
//   state  | meaning
//   IDLE   | EX updates written straight through, one cycle later
//   SWEEP  | one entry cleared per cycle; r_cnt is the index on the port
//   REPLAY | the pending update is on the port this cycle
module btb_maint_ctrl
  import bp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  btb_maint_if.slave bus
);

  maint_state_e         r_state, w_state_nxt;
  logic [BTB_IDX_W-1:0] r_cnt, w_cnt_nxt;
  btb_wr_t              r_wr, w_wr_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_last;
  logic                 w_load;
  logic                 w_consume;
  logic                 w_pend_full;
  logic [BTB_IDX_W-1:0] w_pend_idx;
  btb_entry_t           w_pend_entry;
  btb_entry_t           w_upd_entry;
  logic [BTB_CNT_W-1:0] w_drop_cnt;

  assign w_upd_entry = mk_entry(bus.upd_tag_i, bus.upd_target_i);
  assign w_last      = (r_cnt == BTB_LAST_IDX);
  // Outside IDLE every update goes through the pending buffer, even in REPLAY.
  assign w_load      = bus.upd_valid_i & (bus.inv_req_i | (r_state != IDLE));
  assign w_consume   = (r_state == REPLAY) & ~bus.inv_req_i;

  btb_upd_buf u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_load),
    .i_consume  (w_consume),
    .i_idx      (bus.upd_idx_i),
    .i_entry    (w_upd_entry),
    .o_full     (w_pend_full),
    .o_idx      (w_pend_idx),
    .o_entry    (w_pend_entry),
    .o_drop_cnt (w_drop_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.inv_req_i) begin
      w_state_nxt = SWEEP;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        SWEEP: begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (w_pend_full | w_load) ? REPLAY : IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        REPLAY:  w_state_nxt = bus.upd_valid_i ? REPLAY : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Write-port contents for the next cycle follow the state being entered.
  always_comb begin
    w_wr_nxt   = '0;
    w_done_nxt = (r_state == SWEEP) & w_last & ~bus.inv_req_i;
    case (w_state_nxt)
      SWEEP: begin
        w_wr_nxt.we  = 1'b1;
        w_wr_nxt.idx = w_cnt_nxt;
      end
      REPLAY: begin
        w_wr_nxt.we    = 1'b1;
        w_wr_nxt.idx   = w_load ? bus.upd_idx_i : w_pend_idx;
        w_wr_nxt.entry = w_load ? w_upd_entry : w_pend_entry;
      end
      default: begin
        if ((r_state == IDLE) && bus.upd_valid_i) begin
          w_wr_nxt.we    = 1'b1;
          w_wr_nxt.idx   = bus.upd_idx_i;
          w_wr_nxt.entry = w_upd_entry;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr   <= '0;
      r_done <= 1'b0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.btb_we_o       = r_wr.we;
  assign bus.btb_widx_o     = r_wr.idx;
  assign bus.btb_wtag_o     = r_wr.entry.tag;
  assign bus.btb_wvalid_o   = r_wr.entry.valid;
  assign bus.btb_wtarget_o  = r_wr.entry.target;
  assign bus.inv_busy_o     = (r_state == SWEEP);
  assign bus.inv_done_o     = r_done;
  assign bus.lookup_block_o = bus.inv_req_i | (r_state == SWEEP);
  assign bus.drop_cnt_o     = w_drop_cnt;

endmodule
